// File: rtl/input_conditioner_bank.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_bank
// Description : Per-channel synchroniser, debouncer and edge detector with
//               sticky write-1-to-clear event flags.
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner_bank #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               WAIT_CYCLES = 3,
    parameter int               CNT_W       = $clog2(WAIT_CYCLES + 1),
    parameter logic [WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] noisysignal,
    output logic [WIDTH-1:0] conditioned,
    output logic [WIDTH-1:0] positiveedge,
    output logic [WIDTH-1:0] negativeedge,
    input  logic [WIDTH-1:0] flag_clear,
    output logic [WIDTH-1:0] event_flags,
    output logic             any_event
);

    localparam logic [CNT_W-1:0] c_WAIT = CNT_W'(WAIT_CYCLES);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= INIT_VALUE;
            end
        end else begin
            r_sync[0] <= noisysignal;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_lvl;
            logic             r_rise;
            logic             r_fall;

            // Counter clears on acceptance, so it can never pass c_WAIT.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_lvl  <= INIT_VALUE[i];
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (w_s[i] == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt < c_WAIT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_lvl  <= w_s[i];
                        r_cnt  <= '0;
                        r_rise <= w_s[i];
                        r_fall <= ~w_s[i];
                    end
                end
            end

            assign conditioned[i]  = r_lvl;
            assign positiveedge[i] = r_rise;
            assign negativeedge[i] = r_fall;
        end
    endgenerate

    // A set coinciding with a clear wins so no edge is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~flag_clear) | positiveedge | negativeedge;
        end
    end

    assign event_flags = r_flags;
    assign any_event   = |(positiveedge | negativeedge);

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner_bank.sv
`default_nettype none
// Testbench for input_conditioner_bank: directed cases plus randomized traffic,
// scored against a sliding-window reference model through a queue.
module tb_input_conditioner_bank;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int WT   = 3;
    localparam int WIN  = WT + 1;

    typedef struct packed {
        logic [W-1:0] cond;
        logic [W-1:0] pos;
        logic [W-1:0] neg;
        logic [W-1:0] flags;
        logic         any;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] noisysignal;
    logic [W-1:0] conditioned;
    logic [W-1:0] positiveedge;
    logic [W-1:0] negativeedge;
    logic [W-1:0] flag_clear;
    logic [W-1:0] event_flags;
    logic         any_event;

    int n_cmp = 0;
    int n_err = 0;

    obs_t sb[$];

    // Reference model state: delay line, history window of the synchronised level.
    logic [W-1:0] m_sync [SYNC];
    logic [W-1:0] m_win  [WIN];
    logic [W-1:0] m_c, m_pos, m_neg, m_flags;

    input_conditioner_bank #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .WAIT_CYCLES(WT)
    ) dut (
        .clk(clk), .reset(reset), .noisysignal(noisysignal),
        .conditioned(conditioned), .positiveedge(positiveedge),
        .negativeedge(negativeedge), .flag_clear(flag_clear),
        .event_flags(event_flags), .any_event(any_event)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // A channel's level flips once the synchronised input has disagreed with it
    // on the most recent WAIT_CYCLES+1 consecutive clocks.
    task automatic model_edge(input logic [W-1:0] n, input logic [W-1:0] clr, input logic r);
        logic [W-1:0] s_pre, acc;
        if (r) begin
            for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
            for (int k = 0; k < WIN; k++)  m_win[k]  = '0;
            m_c = '0; m_pos = '0; m_neg = '0; m_flags = '0;
        end else begin
            s_pre = m_sync[SYNC-1];
            for (int k = WIN-1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = s_pre;
            acc = '1;
            for (int k = 0; k < WIN; k++) acc &= (m_win[k] ^ m_c);
            m_flags = (m_flags & ~clr) | m_pos | m_neg;
            m_pos   = acc & ~m_c;
            m_neg   = acc & m_c;
            m_c     = m_c ^ acc;
            for (int k = SYNC-1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = n;
        end
        sb.push_back('{cond: m_c, pos: m_pos, neg: m_neg, flags: m_flags,
                       any: |(m_pos | m_neg)});
    endtask

    task automatic step(input logic [W-1:0] n, input logic [W-1:0] clr, input logic r);
        @(negedge clk);
        noisysignal = n;
        flag_clear  = clr;
        reset       = r;
        @(posedge clk);
        model_edge(n, clr, r);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [W-1:0] n, input logic [W-1:0] clr, input int cyc);
        for (int k = 0; k < cyc; k++) step(n, clr, 1'b0);
    endtask

    task automatic run_cnt(input logic [W-1:0] n, input int cyc, input int ch,
                           inout int np, inout int nn);
        for (int k = 0; k < cyc; k++) begin
            step(n, '0, 1'b0);
            #1;
            np += int'(positiveedge[ch]);
            nn += int'(negativeedge[ch]);
        end
    endtask

    // Monitor: every cycle presents one observation, checked against the queue.
    always @(negedge clk) begin
        obs_t got, e;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = '{cond: conditioned, pos: positiveedge, neg: negativeedge,
                    flags: event_flags, any: any_event};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL sb @%0t: got c=%h p=%h n=%h f=%h a=%b required c=%h p=%h n=%h f=%h a=%b",
                         $time, got.cond, got.pos, got.neg, got.flags, got.any,
                         e.cond, e.pos, e.neg, e.flags, e.any);
            end
        end
    end

    initial begin
        int np, nn;
        logic [W-1:0] lv, clr;
        logic r;
        noisysignal = '0;
        flag_clear  = '0;
        reset       = 1'b1;

        // Reset with all inputs high, then release and measure latency.
        step(8'hFF, 8'h00, 1'b1);
        step(8'hFF, 8'h00, 1'b1);
        #1;
        chk("rst_cond", conditioned, 8'h00);
        chk("rst_pos", positiveedge, 8'h00);
        chk("rst_any", {7'b0, any_event}, 8'h00);
        for (int k = 0; k < 5; k++) step(8'hFF, 8'h00, 1'b0);
        #1;
        chk("lat_cond_early", conditioned, 8'h00);
        step(8'hFF, 8'h00, 1'b0);
        #1;
        chk("lat_cond", conditioned, 8'hFF);
        chk("lat_pos", positiveedge, 8'hFF);
        chk("lat_any", {7'b0, any_event}, 8'h01);
        step(8'hFF, 8'h00, 1'b0);
        #1;
        chk("pos_one_cycle", positiveedge, 8'h00);
        chk("any_one_cycle", {7'b0, any_event}, 8'h00);

        // Bounce on ch0.
        run(8'h00, 8'h00, 12);
        np = 0; nn = 0;
        for (int k = 0; k < 8; k++) run_cnt({7'b0, k[0]}, 1, 0, np, nn);
        run_cnt(8'h01, 12, 0, np, nn);
        chk("bounce_pos_cnt", 8'(np), 8'd1);
        chk("bounce_neg_cnt", 8'(nn), 8'd0);

        // Short glitches on ch3.
        run(8'h00, 8'h00, 12);
        np = 0; nn = 0;
        run_cnt(8'h08, 3, 3, np, nn);
        run_cnt(8'h00, 12, 3, np, nn);
        chk("glitch3_pos", 8'(np), 8'd0);
        chk("glitch3_neg", 8'(nn), 8'd0);
        np = 0; nn = 0;
        run_cnt(8'h08, 4, 3, np, nn);
        run_cnt(8'h00, 12, 3, np, nn);
        chk("glitch4_pos", 8'(np), 8'd1);
        chk("glitch4_neg", 8'(nn), 8'd1);

        // ch1 rises while ch2 falls.
        run(8'h04, 8'h00, 12);
        run(8'h02, 8'h00, 5);
        step(8'h02, 8'h00, 1'b0);
        #1;
        chk("indep_pos", positiveedge, 8'h02);
        chk("indep_neg", negativeedge, 8'h04);

        // Flag set/clear collision on ch5.
        run(8'h00, 8'hFF, 12);
        run(8'h20, 8'h00, 5);
        step(8'h20, 8'h00, 1'b0);
        #1;
        chk("flag_pos5", positiveedge, 8'h20);
        step(8'h20, 8'h20, 1'b0);
        #1;
        chk("flag_set_wins", {7'b0, event_flags[5]}, 8'h01);
        step(8'h20, 8'h20, 1'b0);
        #1;
        chk("flag_cleared", {7'b0, event_flags[5]}, 8'h00);

        // Reset while the ch0 counter holds 2.
        run(8'h00, 8'hFF, 12);
        run(8'h01, 8'h00, 4);
        step(8'h01, 8'h00, 1'b1);
        np = 0; nn = 0;
        run_cnt(8'h01, 5, 0, np, nn);
        chk("mid_rst_no_pulse", 8'(np), 8'd0);
        chk("mid_rst_cond", {7'b0, conditioned[0]}, 8'h00);
        step(8'h01, 8'h00, 1'b0);
        #1;
        chk("mid_rst_pulse", positiveedge, 8'h01);

        // Randomized traffic: slowly flipping levels, random clears, rare resets.
        lv = '0;
        for (int k = 0; k < 3000; k++) begin
            lv  = lv ^ W'($urandom & $urandom & $urandom);
            clr = W'($urandom & $urandom);
            r   = ($urandom_range(0, 199) == 0);
            step(lv, clr, r);
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
